// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   Adds two WIDTH-bit operands one nibble per cycle through a single 4-bit
//   ripple-carry slice, least-significant nibble first. The carry is held in a
//   register between nibbles. Operands enter on a valid/ready handshake, and the
//   result leaves on another valid/ready handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   input_1, input_2      operands A and B (WIDTH bits)
//   c_in                  carry into bit 0
//   out_valid / out_ready result handshake (out_valid is high only in DONE)
//   sum                   A + B + c_in modulo 2^WIDTH
//   c_out                 carry out of bit WIDTH-1
//   overflow              two's-complement overflow of the addition
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  // Reject widths the nibble datapath cannot represent.
  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $fatal(1, "nibble_serial_adder_ctrl: WIDTH=%0d must be a multiple of 4 and >= 4", WIDTH);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q,    state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;
  logic [WIDTH-1:0]   sum_q,      sum_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               carry_q,    carry_d;
  logic               c_out_q,    c_out_d;
  logic               overflow_q, overflow_d;

  // 4-bit ripple slice: operand shift registers always present the current
  // nibble in their low four bits.
  logic [3:0] slice_a;
  logic [3:0] slice_b;
  logic [3:0] slice_low3;
  logic [4:0] slice_full;
  logic [3:0] slice_sum;
  logic       slice_c3;
  logic       slice_co;

  always_comb begin
    slice_a    = a_q[3:0];
    slice_b    = b_q[3:0];
    // Lower three bits alone give the carry into bit 3 (needed for overflow).
    slice_low3 = {1'b0, slice_a[2:0]} + {1'b0, slice_b[2:0]} + {3'b000, carry_q};
    slice_full = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};
    slice_sum  = slice_full[3:0];
    slice_c3   = slice_low3[3];
    slice_co   = slice_full[4];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        // Operands are sampled only on an accepted handshake, so X on the
        // operand buses while in_valid is low never reaches state.
        if (in_valid && in_ready_q) begin
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          a_d        = input_1;
          b_d        = input_2;
          carry_d    = c_in;
          cnt_d      = '0;
        end
      end

      S_RUN: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_co;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (cnt_q == CNT_W'(NIB - 1)) begin
          // Final nibble: counter stays at NIB-1 until the next accept.
          c_out_d     = slice_co;
          overflow_d  = slice_c3 ^ slice_co;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands by passing them four bits per cycle through a single internal 4-bit ripple-carry slice, least-significant nibble first, with the carry held in a register between nibbles. It trades latency for area against a full-width adder. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand producer and a result consumer in the arithmetic datapath.

Parameters:
WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 4. Any other value is a fatal elaboration error.
NIB, WIDTH/4, number of nibbles. This is a derived localparam, not overridable.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and c_in are valid
in_ready  output  1  block can accept operands
input_1  input  WIDTH  operand A
input_2  input  WIDTH  operand B
c_in  input  1  carry into bit 0
out_valid  output  1  sum, c_out and overflow are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  A + B + c_in, modulo 2^WIDTH
c_out  output  1  carry out of bit WIDTH-1
overflow  output  1  two's-complement overflow, equal to carry into bit WIDTH-1 XOR c_out

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, c_out=0, overflow=0.
  - Nibble counter=0, carry register=0, operand shift registers=0.
- States:
  - IDLE -> RUN on (in_valid & in_ready). On that edge, latch input_1, input_2 and c_in; set carry register=c_in and counter=0.
  - RUN: each cycle, add nibble[counter] of A and B plus the carry register through the 4-bit slice.
    - At the edge, write the 4-bit result into sum[4*counter+3 : 4*counter] and the slice carry-out into the carry register, then increment the counter.
    - On the edge where counter==NIB-1: capture c_out from the slice carry-out and overflow from (carry into bit 3 of the slice) XOR (slice carry-out), then go to DONE.
  - DONE: out_valid=1. Go to IDLE on out_ready.
- Handshake rules:
  - in_ready=1 only in IDLE.
  - in_valid in RUN or DONE is ignored; operands are not sampled.
  - in_ready and out_valid are never 1 in the same cycle.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 cycles for WIDTH=16).
- Throughput: one addition per NIB+2 cycles at best. The minimum is NIB RUN cycles + 1 DONE cycle with out_ready=1 + 1 IDLE cycle; there is no bypass from DONE to accept.
- Output stability:
  - sum, c_out and overflow hold stable while out_valid=1 and out_ready=0, for any number of cycles.
  - After the result is handed off, these outputs keep their last value until the next RUN overwrites them. Consumers must qualify them with out_valid.
  - sum is updated one nibble per RUN cycle. It is not meaningful while out_valid=0.
- Arithmetic:
  - Unsigned: {c_out, sum} = A + B + c_in exactly.
  - Signed: overflow=1 iff A and B have the same sign bit and sum's sign bit differs.
- Boundary conditions:
  - WIDTH=4: NIB=1, a single RUN cycle.
  - The counter never exceeds NIB-1 and wraps to 0 only via a new accept.
  - Reset asserted mid-RUN or in DONE aborts immediately: the partial result is discarded and out_valid=0 asynchronously.
  - X on input_1/input_2 while in_valid=0 must not propagate into state.

Test Plan:
- WIDTH=16, input_1=0x1234, input_2=0x1111, c_in=0, accepted at edge T -> out_valid first high after edge T+4; sum=0x2345, c_out=0, overflow=0.
- input_1=0xFFFF, input_2=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0; the carry ripples through all four nibbles.
- input_1=0x7FFF, input_2=0x0000, c_in=1 -> sum=0x8000, c_out=0, overflow=1. Then input_1=0x8000, input_2=0x8000, c_in=0 -> sum=0x0000, c_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> outputs stable, in_ready=0 throughout, and a second operand pair presented with in_valid=1 is not accepted. On out_ready=1, the block returns to IDLE; the second pair is then accepted and its result is correct.
- Reset mid-operation: drive rst_n=0 asynchronously between clock edges, 2 cycles into RUN -> out_valid=0, in_ready=1 and sum=0 immediately. After release, a new 0x00FF + 0x0001 yields 0x0100, c_out=0.
- Repeat the first three checks with WIDTH=4 (0xF+0x1 -> sum=0x0, c_out=1, out_valid one cycle after accept) and with WIDTH=32, using randomized back-to-back traffic checked against a reference model.
